// File: rtl/vga_pkg.sv
// Shared timing defaults, helpers and pixel type for the VGA scan-out engine.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 8;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_scanout_sig_delay.sv
// Synchronous-reset shift register; DEPTH=0 degenerates to a plain wire.
module sig_delay #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            // Shift d through DEPTH stages, all cleared to RST_VAL on reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scanout.sv
// Parametrised VGA scan-out: pixel/line counters, incremental framebuffer
// address, and sync/blank delayed to line up with the returned pixel data.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int PIX_DIV  = 1,
    parameter int RD_LAT   = 1,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int AW       = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [9:0]             h_addr,
    output logic [9:0]             v_addr,
    output logic [AW-1:0]          rd_addr,
    output logic                   rd_en,
    input  logic [3*COLOR_W-1:0]   rd_data,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic                   vga_valid,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   pix_ce,
    output logic                   frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int CW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [CW-1:0] CE_LAST  = CW'(PIX_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW-1:0] ADDR_END = AW'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic          SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          SYNC_OFF = ~SYNC_ON;

    logic [CW-1:0] ce_cnt;
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          pix_end;
    logic          h_wrap;
    logic          frame_wrap;
    logic          raw_valid;
    logic          raw_hs;
    logic          raw_vs;
    logic [2:0]    dly;

    assign pix_end    = (ce_cnt == CE_LAST);
    assign h_wrap     = pix_end && (hc == H_LAST);
    assign frame_wrap = h_wrap && (vc == V_LAST);
    assign raw_valid  = (hc < H_ACT) && (vc < V_ACT);
    assign raw_hs     = ((hc >= HS_BEG) && (hc < HS_END)) ? SYNC_ON : SYNC_OFF;
    assign raw_vs     = ((vc >= VS_BEG) && (vc < VS_END)) ? SYNC_ON : SYNC_OFF;

    // Strobes live in the counter domain; masked while reset is held
    assign pix_ce      = (ce_cnt == CW'(0));
    assign frame_start = pix_ce && (hc == 10'd0) && (vc == 10'd0) && !rst;
    assign rd_en       = pix_ce && raw_valid && !rst;
    assign h_addr      = hc;
    assign v_addr      = vc;

    // Prescaler, raster counters and incremental read address; all step at pixel end
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_cnt  <= '0;
            hc      <= 10'd0;
            vc      <= 10'd0;
            rd_addr <= '0;
        end else begin
            ce_cnt <= pix_end ? '0 : ce_cnt + CW'(1);
            if (pix_end) begin
                hc <= h_wrap ? 10'd0 : hc + 10'd1;
                if (h_wrap) begin
                    vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
                end
                // Last active pixel clears the address so it never reaches H_ACTIVE*V_ACTIVE
                if (frame_wrap || (raw_valid && (rd_addr == ADDR_END))) begin
                    rd_addr <= '0;
                end else if (raw_valid) begin
                    rd_addr <= rd_addr + AW'(1);
                end
            end
        end
    end

    sig_delay #(
        .W       (3),
        .DEPTH   (RD_LAT),
        .RST_VAL ({SYNC_OFF, SYNC_OFF, 1'b0})
    ) u_timing_dly (
        .clk (clk),
        .rst (rst),
        .d   ({raw_hs, raw_vs, raw_valid}),
        .q   (dly)
    );

    // Output stage: sync/blank and colour registered together, colour forced to 0 in blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync <= SYNC_OFF;
            vga_vsync <= SYNC_OFF;
            vga_valid <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            vga_hsync <= dly[2];
            vga_vsync <= dly[1];
            vga_valid <= dly[0];
            {vga_r, vga_g, vga_b} <= dly[0] ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: eight instances (latency/divider/polarity variants)
// checked each cycle against an arithmetic raster model, plus period tables.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int NG = 8;
    localparam int BIG_VA = 60;
    localparam int BIG_LIM = 640 * BIG_VA;

    function automatic int lat_of(input int g);
        case (g)
            5:       return 2;
            6, 7:    return 1;
            default: return g;
        endcase
    endfunction

    function automatic int pd_of(input int g);
        return (g == 5) ? 3 : 1;
    endfunction

    function automatic int pol_of(input int g);
        return (g == 6) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_small = 1'b1;
    logic rst_big   = 1'b1;
    logic model_on  = 1'b0;
    int   t_small   = 0;
    int   t_big     = 0;
    int   vecs      = 0;
    int   errs      = 0;
    logic [4:0] obs [NG];

    task automatic chk(input string name, input int g, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, g, act, exp);
        end
    endtask

    always @(posedge clk) begin
        t_small <= rst_small ? 0 : t_small + 1;
        t_big   <= rst_big   ? 0 : t_big + 1;
    end

    generate
        for (genvar g = 0; g < NG; g++) begin : g_dut
            localparam int LAT = lat_of(g);
            localparam int PD  = pd_of(g);
            localparam int POL = pol_of(g);
            localparam bit BIG = (g == 7);
            localparam int HA  = BIG ? 640 : 4;
            localparam int HF  = BIG ? 16 : 1;
            localparam int HS  = BIG ? 96 : 2;
            localparam int HB  = BIG ? 48 : 1;
            localparam int VA  = BIG ? BIG_VA : 3;
            localparam int VF  = 1;
            localparam int VS  = 1;
            localparam int VB  = 1;
            localparam int HT  = HA + HF + HS + HB;
            localparam int VT  = VA + VF + VS + VB;

            logic        rst_g;
            logic [9:0]  h_addr, v_addr;
            logic [18:0] rd_addr;
            logic        rd_en, vga_hsync, vga_vsync, vga_valid, pix_ce, frame_start;
            logic [23:0] rd_data;
            rgb_t        pix;
            logic [18:0] hist [5];
            int          max_addr = 0;

            assign rst_g = BIG ? rst_big : rst_small;

            vga_scanout #(
                .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                .SYNC_POL(POL), .PIX_DIV(PD), .RD_LAT(LAT), .COLOR_W(8), .AW(19)
            ) u_dut (
                .clk(clk), .rst(rst_g), .h_addr(h_addr), .v_addr(v_addr),
                .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
                .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_valid(vga_valid),
                .vga_r(pix.r), .vga_g(pix.g), .vga_b(pix.b),
                .pix_ce(pix_ce), .frame_start(frame_start)
            );

            // Framebuffer model: data equals address, returned LAT cycles later
            always @(posedge clk) begin
                hist[0] <= rd_addr;
                for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
            end
            if (LAT == 0) begin : g_fb0
                assign rd_data = {5'd0, rd_addr};
            end else begin : g_fbn
                assign rd_data = {5'd0, hist[LAT-1]};
            end

            assign obs[g] = {pix_ce, vga_valid, vga_vsync == POL[0], vga_hsync == POL[0], frame_start};

            // Reference model: raster position from elapsed cycles since reset
            always @(negedge clk) begin
                int t, p, ph, hc, vc, s, hc2, vc2;
                logic r, v, v2, ehs, evs;
                logic [23:0] ergb;
                if (model_on) begin
                    t  = BIG ? t_big : t_small;
                    r  = BIG ? rst_big : rst_small;
                    p  = t / PD;
                    ph = t % PD;
                    hc = p % HT;
                    vc = (p / HT) % VT;
                    v  = (hc < HA) && (vc < VA);
                    chk("h_addr", g, h_addr, hc);
                    chk("v_addr", g, v_addr, vc);
                    chk("pix_ce", g, pix_ce, ph == 0);
                    chk("frame_start", g, frame_start, !r && ph == 0 && hc == 0 && vc == 0);
                    chk("rd_en", g, rd_en, !r && ph == 0 && v);
                    if (v) chk("rd_addr", g, rd_addr, vc * HA + hc);
                    chk("rd_addr_range", g, rd_addr < HA * VA, 1);
                    if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
                    ehs = !POL[0];
                    evs = !POL[0];
                    v2 = 1'b0;
                    ergb = 24'd0;
                    if (t >= LAT + 1) begin
                        s   = (t - LAT - 1) / PD;
                        hc2 = s % HT;
                        vc2 = (s / HT) % VT;
                        v2  = (hc2 < HA) && (vc2 < VA);
                        if (hc2 >= HA + HF && hc2 < HA + HF + HS) ehs = POL[0];
                        if (vc2 >= VA + VF && vc2 < VA + VF + VS) evs = POL[0];
                        if (v2) ergb = 24'(vc2 * HA + hc2);
                    end
                    chk("vga_hsync", g, vga_hsync, ehs);
                    chk("vga_vsync", g, vga_vsync, evs);
                    chk("vga_valid", g, vga_valid, v2);
                    chk("vga_rgb", g, pix, ergb);
                end
            end
        end
    endgenerate

    typedef struct {
        string name;
        int    g;
        int    kind;
        int    expv;
    } vec_t;

    vec_t tab[13];
    int   cnt [NG][5];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // kinds: 0 frame_start, 1 hsync active, 2 vsync active, 3 valid, 4 pix_ce (per 288 clk)
        tab[0]  = '{"fs_lat1", 1, 0, 6};
        tab[1]  = '{"hs_lat1", 1, 1, 72};
        tab[2]  = '{"vs_lat1", 1, 2, 48};
        tab[3]  = '{"valid_lat1", 1, 3, 72};
        tab[4]  = '{"valid_lat0", 0, 3, 72};
        tab[5]  = '{"valid_lat4", 4, 3, 72};
        tab[6]  = '{"fs_div3", 5, 0, 2};
        tab[7]  = '{"ce_div3", 5, 4, 96};
        tab[8]  = '{"valid_div3", 5, 3, 72};
        tab[9]  = '{"hs_div3", 5, 1, 72};
        tab[10] = '{"hs_pol1", 6, 1, 72};
        tab[11] = '{"vs_pol1", 6, 2, 48};
        tab[12] = '{"ce_div1", 2, 4, 288};

        repeat (3) @(posedge clk);
        #1;
        rst_small = 1'b0;
        rst_big   = 1'b0;
        model_on  = 1'b1;

        // Mid-frame reset while the small raster sits at (5,2)
        for (int i = 0; i < 200 && t_small != 21; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reach_5_2", 1, t_small, 21);
        rst_small = 1'b1;
        @(posedge clk);
        #1;
        rst_small = 1'b0;
        @(negedge clk);
        chk("rst_hsync", 1, g_dut[1].vga_hsync, 1);
        chk("rst_vsync", 1, g_dut[1].vga_vsync, 1);
        chk("rst_valid", 1, g_dut[1].vga_valid, 0);
        chk("rst_rgb", 1, g_dut[1].pix, 0);
        chk("rst_h_addr", 1, g_dut[1].h_addr, 0);
        chk("rst_v_addr", 1, g_dut[1].v_addr, 0);
        chk("rst_rd_addr", 1, g_dut[1].rd_addr, 0);
        chk("rst_frame_start", 1, g_dut[1].frame_start, 1);
        chk("rst_hsync_pol1", 6, g_dut[6].vga_hsync, 0);
        chk("rst_vsync_pol1", 6, g_dut[6].vga_vsync, 0);

        // Period counts over a 288-clk steady-state window
        repeat (20) @(negedge clk);
        for (int g = 0; g < NG; g++)
            for (int k = 0; k < 5; k++) cnt[g][k] = 0;
        for (int i = 0; i < 288; i++) begin
            @(negedge clk);
            for (int g = 0; g < NG; g++)
                for (int k = 0; k < 5; k++) cnt[g][k] += int'(obs[g][k]);
        end
        for (int i = 0; i < 13; i++) chk(tab[i].name, tab[i].g, cnt[tab[i].g][tab[i].kind], tab[i].expv);

        // Random reset pulses on the small rasters while the large one runs past a frame
        while (t_big < 51000 && errs < 50) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 199) == 0) begin
                rst_small = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                rst_small = 1'b0;
            end
        end
        @(negedge clk);
        chk("big_max_addr", 7, g_dut[7].max_addr, BIG_LIM - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
